// File: rtl/uart_baud_gen_frac_pkg.sv
// rtl/uart_baud_gen_frac_pkg.sv - shared defaults and divisor helper for the fractional baud generator
package uart_baud_gen_frac_pkg;

    localparam int SYS_CLK         = 50_000_000;
    localparam int UART_BAUD_RATE  = 115_200;
    localparam int UART_OVERSAMPLE = 16;
    localparam int BAUD_DIV_INT_W  = 16;
    localparam int BAUD_DIV_FRAC_W = 4;

    // Divisor in units of 1/2^frac_w clock, rounded to nearest.
    function automatic longint calc_div(input longint sys_clk, input longint baud,
                                        input longint os, input int frac_w);
        longint den;
        den = baud * os;
        return ((sys_clk << frac_w) * 2 + den) / (2 * den);
    endfunction

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// rtl/uart_baud_gen_frac_if.sv - control and tick bundle between UART core and baud generator
interface uart_baud_gen_frac_if
    import uart_baud_gen_frac_pkg::*;
#(
    parameter int P_DIV_INT_W  = BAUD_DIV_INT_W,
    parameter int P_DIV_FRAC_W = BAUD_DIV_FRAC_W
);
    logic                    i_en;
    logic                    i_div_load;
    logic [P_DIV_INT_W-1:0]  i_div_int;
    logic [P_DIV_FRAC_W-1:0] i_div_frac;
    logic                    i_resync;
    logic                    o_os_tick;
    logic                    o_mid_tick;
    logic                    o_baud_tick;
    logic                    o_u_clk;
    logic                    o_cfg_err;

    modport master (
        output i_en, i_div_load, i_div_int, i_div_frac, i_resync,
        input  o_os_tick, o_mid_tick, o_baud_tick, o_u_clk, o_cfg_err
    );

    modport slave (
        input  i_en, i_div_load, i_div_int, i_div_frac, i_resync,
        output o_os_tick, o_mid_tick, o_baud_tick, o_u_clk, o_cfg_err
    );
endinterface

// File: rtl/uart_frac_div.sv
// rtl/uart_frac_div.sv - integer+fractional period counter with shadowed divisor, one strobe per period
module uart_frac_div
    import uart_baud_gen_frac_pkg::*;
#(
    parameter int                INT_W    = BAUD_DIV_INT_W,
    parameter int                FRAC_W   = BAUD_DIV_FRAC_W,
    parameter logic [INT_W-1:0]  DEF_INT  = INT_W'(2),
    parameter logic [FRAC_W-1:0] DEF_FRAC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic              div_load,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              resync,
    output logic              os_stb
);
    logic [INT_W-1:0]  cnt;
    logic [INT_W-1:0]  act_int;
    logic [INT_W-1:0]  shd_int;
    logic [INT_W-1:0]  ld_int;
    logic [INT_W-1:0]  nxt_int;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] shd_frac;
    logic [FRAC_W-1:0] nxt_frac;
    logic              carry;
    logic              shd_vld;
    logic [INT_W:0]    len;
    logic [FRAC_W:0]   sum;

    assign ld_int = (div_int < INT_W'(2)) ? INT_W'(2) : div_int;
    assign len    = {1'b0, act_int} + {{INT_W{1'b0}}, carry};
    assign os_stb = en && !resync && ({1'b0, cnt} == (len - {{INT_W{1'b0}}, 1'b1}));

    // Divisor that takes over at this period boundary; a load landing on the boundary wins.
    always_comb begin
        nxt_int  = act_int;
        nxt_frac = act_frac;
        if (div_load) begin
            nxt_int  = ld_int;
            nxt_frac = div_frac;
        end else if (shd_vld) begin
            nxt_int  = shd_int;
            nxt_frac = shd_frac;
        end
    end

    assign sum = {1'b0, acc} + {1'b0, nxt_frac};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            act_int  <= DEF_INT;
            act_frac <= DEF_FRAC;
            shd_int  <= '0;
            shd_frac <= '0;
            shd_vld  <= 1'b0;
        end else if (resync) begin
            cnt   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            if (div_load) begin
                act_int  <= ld_int;
                act_frac <= div_frac;
                shd_vld  <= 1'b0;
            end
        end else if (div_load && !en) begin
            act_int  <= ld_int;
            act_frac <= div_frac;
            shd_vld  <= 1'b0;
        end else if (os_stb) begin
            cnt      <= '0;
            act_int  <= nxt_int;
            act_frac <= nxt_frac;
            shd_vld  <= 1'b0;
            acc      <= sum[FRAC_W-1:0];
            carry    <= sum[FRAC_W];
        end else begin
            if (en) begin
                cnt <= cnt + INT_W'(1);
            end
            if (div_load) begin
                shd_int  <= ld_int;
                shd_frac <= div_frac;
                shd_vld  <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_baud_gen_frac.sv
// rtl/uart_baud_gen_frac.sv - oversample, mid-bit and baud tick generator with fractional divisor
module uart_baud_gen_frac
    import uart_baud_gen_frac_pkg::*;
#(
    parameter int P_SYS_CLK        = SYS_CLK,
    parameter int P_UART_BAUD_RATE = UART_BAUD_RATE,
    parameter int P_OVERSAMPLE     = UART_OVERSAMPLE,
    parameter int P_DIV_INT_W      = BAUD_DIV_INT_W,
    parameter int P_DIV_FRAC_W     = BAUD_DIV_FRAC_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    uart_baud_gen_frac_if.slave  bus
);
    localparam longint                  DEF_DIV  = calc_div(P_SYS_CLK, P_UART_BAUD_RATE,
                                                            P_OVERSAMPLE, P_DIV_FRAC_W);
    localparam logic [P_DIV_INT_W-1:0]  DEF_INT  = P_DIV_INT_W'(DEF_DIV >> P_DIV_FRAC_W);
    localparam logic [P_DIV_FRAC_W-1:0] DEF_FRAC = P_DIV_FRAC_W'(DEF_DIV);
    localparam int                      OS_W     = $clog2(P_OVERSAMPLE);
    localparam logic [OS_W-1:0]         OS_LAST  = OS_W'(P_OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]         OS_HALF  = OS_W'(P_OVERSAMPLE / 2);

    logic            os_stb;
    logic [OS_W-1:0] os_cnt;
    logic [OS_W-1:0] os_cnt_nxt;
    logic            os_tick;
    logic            mid_tick;
    logic            baud_tick;
    logic            u_clk;
    logic            cfg_err;

    uart_frac_div #(
        .INT_W    (P_DIV_INT_W),
        .FRAC_W   (P_DIV_FRAC_W),
        .DEF_INT  (DEF_INT),
        .DEF_FRAC (DEF_FRAC)
    ) u_div (
        .clock    (clock),
        .reset_n  (reset_n),
        .en       (bus.i_en),
        .div_load (bus.i_div_load),
        .div_int  (bus.i_div_int),
        .div_frac (bus.i_div_frac),
        .resync   (bus.i_resync),
        .os_stb   (os_stb)
    );

    assign os_cnt_nxt = (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            os_cnt    <= '0;
            os_tick   <= 1'b0;
            mid_tick  <= 1'b0;
            baud_tick <= 1'b0;
            u_clk     <= 1'b1;
            cfg_err   <= 1'b0;
        end else begin
            if (bus.i_div_load && (bus.i_div_int < P_DIV_INT_W'(2))) begin
                cfg_err <= 1'b1;
            end
            if (bus.i_resync) begin
                os_cnt    <= '0;
                os_tick   <= 1'b0;
                mid_tick  <= 1'b0;
                baud_tick <= 1'b0;
                u_clk     <= 1'b1;
            end else if (os_stb) begin
                os_cnt    <= os_cnt_nxt;
                os_tick   <= 1'b1;
                mid_tick  <= (os_cnt_nxt == OS_HALF);
                baud_tick <= (os_cnt_nxt == '0);
                u_clk     <= (os_cnt_nxt < OS_HALF);
            end else begin
                os_tick   <= 1'b0;
                mid_tick  <= 1'b0;
                baud_tick <= 1'b0;
            end
        end
    end

    assign bus.o_os_tick   = os_tick;
    assign bus.o_mid_tick  = mid_tick;
    assign bus.o_baud_tick = baud_tick;
    assign bus.o_u_clk     = u_clk;
    assign bus.o_cfg_err   = cfg_err;
endmodule

// File: doc/uart_baud_gen_frac.md
Name: uart_baud_gen_frac

Overview:
Parametrised successor to the fixed-ratio UART clock divider. It generates single-cycle oversample ticks, baud ticks and mid-bit sample ticks from the system clock. Period control uses a runtime-programmable integer+fractional divisor, so the baud error stays below one system clock averaged over any bit. It feeds the UART TX (baud tick / o_u_clk) and RX (oversample, mid-bit, resync) paths.

Parameters:
P_SYS_CLK, `SYS_CLK, system clock frequency (Hz)
P_UART_BAUD_RATE, `UART_BAUD_RATE, reset-default baud rate (bps)
P_OVERSAMPLE, 16, oversample ticks per bit; even, >= 4
P_DIV_INT_W, 16, width of integer divisor field
P_DIV_FRAC_W, 4, width of fractional divisor field (units of 1/2^P_DIV_FRAC_W clock)

Ports:
clock  in  1  system clock; the block's only clock
reset_n  in  1  asynchronous, active-low reset
i_en  in  1  run enable; low freezes all counters
i_div_load  in  1  one-cycle strobe; captures i_div_int/i_div_frac into shadow
i_div_int  in  P_DIV_INT_W  integer clocks per oversample tick
i_div_frac  in  P_DIV_FRAC_W  fractional clocks per oversample tick
i_resync  in  1  one-cycle strobe; restart bit phase (RX start-edge detect)
o_os_tick  out  1  one-cycle pulse per oversample period
o_mid_tick  out  1  one-cycle pulse at bit centre
o_baud_tick  out  1  one-cycle pulse at bit boundary
o_u_clk  out  1  bit-rate square wave, high in first half of bit
o_cfg_err  out  1  sticky: loaded i_div_int < 2 (clamped)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (async assert, sync release): active divisor = default D = round(P_SYS_CLK*2^F/(P_UART_BAUD_RATE*P_OVERSAMPLE)), split into int/frac (F = P_DIV_FRAC_W). Reset values: period cnt 0, frac acc 0, os_cnt 0, shadow empty. Outputs: o_os_tick/o_mid_tick/o_baud_tick 0, o_u_clk 1, o_cfg_err 0.
- Period counter: counts 0..L-1 on clocks with i_en=1. L = div_int + carry. carry is the carry-out of the (F+1)-bit sum acc + div_frac, computed when the previous period ended; acc keeps the low F bits. The first period after reset/resync has carry=0.
- o_os_tick: registered; high for exactly one clock when the counter wraps. The first tick occurs L enabled clocks after reset release or resync.
- os_cnt: counts 0..P_OVERSAMPLE-1, advancing on each os tick and wrapping to 0.
  - o_baud_tick is asserted with the os tick that wraps os_cnt to 0.
  - o_mid_tick is asserted with the os tick that moves os_cnt to P_OVERSAMPLE/2.
  - o_u_clk is registered as (os_cnt_next < P_OVERSAMPLE/2); all ticks are aligned to the same edge.
- Divisor update: i_div_load writes the shadow register; the shadow becomes active at the next os tick (glitch-free period change). A second load before that tick overwrites the shadow. If i_en=0, the load applies immediately. i_div_int < 2 is clamped to 2 and sets o_cfg_err, which clears only on reset.
- i_resync: next clock sets period cnt=0, acc=0, os_cnt=0. No tick is emitted in that cycle, even if a wrap would have occurred. Works with i_en low.
- i_resync and i_div_load in the same cycle: new divisor active immediately, then restart.
- i_en low: all counters hold and no ticks are emitted. On re-enable the block continues from the held phase.
- Boundaries: div_frac=0 gives an exact integer period. The acc wrap carry gives exactly div_frac long periods per 2^F ticks. No overflow exists beyond the widths stated.

Decomposition:
- Uart_Defines.v: add `UART_OVERSAMPLE, `BAUD_DIV_INT_W, `BAUD_DIV_FRAC_W next to the existing `SYS_CLK/`UART_BAUD_RATE.
- The default-divisor computation is a localparam inside the block.
- Sub-module uart_frac_div: period counter + fractional accumulator + shadow divisor → os tick.
- Top level adds os_cnt, the mid/baud ticks, o_u_clk and o_cfg_err.

Test Plan:
- Bench P_OVERSAMPLE=4, F=4, load int=5 frac=0, en=1 -> os ticks every 5 clocks; baud tick every 20 clocks; mid tick 10 clocks after each baud tick; o_u_clk 10 high / 10 low.
- Load int=5 frac=8 -> os intervals 5,6,5,6...; 16 os ticks span exactly 88 clocks; baud ticks every 22 clocks.
- Load int=7 mid-period while running at int=5 -> current period completes at 5, next and later periods are 7; no runt or double tick.
- i_resync 3 clocks after a tick (int=5) -> no tick for 5 clocks after resync; the 2nd os tick after resync gives o_mid_tick; the 4th gives o_baud_tick.
- i_en low for 10 clocks mid-period -> no ticks; the first tick after re-enable lands at the remaining count; reset_n pulse mid-bit -> outputs go to reset values at once and the default divisor is restored.
- Load int=1 -> o_cfg_err=1, period behaves as int=2 (tick every 2 clocks); stays set until reset_n.
